aes_round_ctrl: RTL

//  Sequencer for an iterative AES-128 encrypt core: one round datapath reused for 10 rounds.

---
 rtl/aes_pkg.sv | 32 +++
 rtl/aes_rcon_gen.sv | 48 ++++
 rtl/aes_round_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// ============================================================================
//  Module  : aes_pkg
//  Purpose : Shared constants, FSM encoding and the GF(2^8) xtime helper for
//            the iterative AES-128 round controller.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int NR     = 10;                // AES-128 round count
  localparam int DATA_W = 128;               // state / key width
  localparam int RND_W  = $clog2(NR + 1);    // round counter width

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ctrl_state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? XTIME_POLY : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_rcon_gen.sv
// ============================================================================
//  Module  : aes_rcon_gen
//  Purpose : Round-constant register. Loads the initial Rcon when a block is
//            accepted and advances by xtime once per executed round.
//  Ports   : clk      in   clock
//            rst_n    in   asynchronous active-low reset
//            load_i   in   reload initial Rcon (has priority over step_i)
//            step_i   in   advance Rcon by one round
//            rcon_o   out  current Rcon
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       step_i,
  output logic [7:0] rcon_o
);

  logic [7:0] rcon_q;
  logic [7:0] rcon_d;

  always_comb begin
    rcon_d = rcon_q;
    if (load_i) begin
      rcon_d = RCON_INIT;
    end else if (step_i) begin
      rcon_d = xtime(rcon_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcon_q <= RCON_INIT;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon_o = rcon_q;

endmodule

`default_nettype wire

// File: rtl/aes_round_ctrl.sv
// ============================================================================
//  Module  : aes_round_ctrl
//  Purpose : Sequencer for an iterative AES-128 encrypt core. Holds the state
//            and round-key registers, drives an external round function and
//            key-schedule step for NR rounds, and hands the ciphertext out on
//            a valid/ready handshake. One block in flight at a time.
//  Ports   : clk, rst_n                      clock, async active-low reset
//            in_valid/in_ready, key,
//            plain_text                      input block handshake
//            rnd_state, rnd_key, rnd_rcon,
//            rnd_last                        to round function / key schedule
//            rnd_state_nxt, rnd_key_nxt      results back from the datapath
//            out_valid/out_ready,
//            cipher_text                     output block handshake
//            busy                            high in RUN or DONE
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_round_ctrl #(
  parameter int NR     = aes_pkg::NR,
  parameter int DATA_W = aes_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] key,
  input  logic [DATA_W-1:0] plain_text,
  output logic [DATA_W-1:0] rnd_state,
  output logic [DATA_W-1:0] rnd_key,
  output logic [7:0]        rnd_rcon,
  output logic              rnd_last,
  input  logic [DATA_W-1:0] rnd_state_nxt,
  input  logic [DATA_W-1:0] rnd_key_nxt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] cipher_text,
  output logic              busy
);

  import aes_pkg::*;

  localparam int                 CNT_W    = $clog2(NR + 1);
  localparam logic [CNT_W-1:0]   LAST_RND = CNT_W'(NR);

  ctrl_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] key_q;
  logic [CNT_W-1:0]  round_q;

  logic accept;
  logic step;
  logic at_last;

  assign accept  = (state_q == ST_IDLE) && in_valid;
  assign step    = (state_q == ST_RUN);
  assign at_last = (round_q == LAST_RND);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (at_last)   state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;  // unused encoding recovers
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accept performs the initial AddRoundKey; each RUN cycle commits one round.
  // The counter saturates at NR so it can never run past the last round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      key_q   <= '0;
      round_q <= '0;
    end else if (accept) begin
      data_q  <= plain_text ^ key;
      key_q   <= key;
      round_q <= CNT_W'(1);
    end else if (step) begin
      data_q  <= rnd_state_nxt;
      key_q   <= rnd_key_nxt;
      if (!at_last) begin
        round_q <= round_q + CNT_W'(1);
      end
    end
  end

  aes_rcon_gen u_rcon (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .step_i (step),
    .rcon_o (rnd_rcon)
  );

  // Handshake outputs decode the state register only, so there is no
  // combinational path from in_valid or out_ready.
  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign rnd_last    = step && at_last;
  assign rnd_state   = data_q;
  assign rnd_key     = key_q;
  assign cipher_text = data_q;

endmodule

`default_nettype wire
